// File: rtl/mul_pkg.sv
// Shared definitions for the execute-stage multiply functional unit.
// MUL_LATENCY is also consumed by the FU_mul cycle counter, so any change here
// must be mirrored by the multiplier pipeline depth.
package mul_pkg;

    localparam int unsigned MUL_WIDTH   = 32;
    localparam int unsigned MUL_LATENCY = 6;
    localparam int unsigned MUL_HALF    = MUL_WIDTH / 2;

    typedef logic [MUL_WIDTH-1:0]   operand_t;
    typedef logic [2*MUL_WIDTH-1:0] product_t;

    // Two's-complement fix-up for the upper product word. The unsigned product
    // of the raw bit patterns over-counts by 2^W * (a_neg ? B : 0) and
    // 2^W * (b_neg ? A : 0); the 2^(2W) cross term vanishes modulo 2^(2W).
    // The returned value is subtracted from the upper half of the product.
    function automatic operand_t signed_hi_correction(input operand_t a, input operand_t b);
        operand_t corr;
        corr = '0;
        if (a[MUL_WIDTH-1]) begin
            corr = corr + b;
        end
        if (b[MUL_WIDTH-1]) begin
            corr = corr + a;
        end
        return corr;
    endfunction

endpackage

// File: rtl/mul16x16_pp.sv
// Registered unsigned half-width partial-product multiplier.
// Four of these form the second pipeline stage of the 32x32 multiplier.
module mul16x16_pp
    import mul_pkg::*;
#(
    parameter int unsigned PP_WIDTH = MUL_HALF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [PP_WIDTH-1:0]   i_a,
    input  logic [PP_WIDTH-1:0]   i_b,
    output logic [2*PP_WIDTH-1:0] o_p
);

    logic [2*PP_WIDTH-1:0] w_a_ext;
    logic [2*PP_WIDTH-1:0] w_b_ext;
    logic [2*PP_WIDTH-1:0] r_p;

    // Zero-extend so the multiply is evaluated at full product width.
    assign w_a_ext = {{PP_WIDTH{1'b0}}, i_a};
    assign w_b_ext = {{PP_WIDTH{1'b0}}, i_b};

    // Register the partial product; synchronous clear flushes it on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p <= '0;
        end else begin
            r_p <= w_a_ext * w_b_ext;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/pipelined_multiplier_32x32.sv
// Fixed-latency, fully pipelined 32x32 -> 64 multiplier for the multiply FU.
// No handshake: the pair sampled at edge n is on P right after edge n+5.
//   Stage 1: operand registers
//   Stage 2: four 16x16 partial products, signed correction term
//   Stage 3: sum of the two middle partial products
//   Stage 4: low-word add (with carry out) and high-word accumulate
//   Stage 5: signed correction applied to the high word
//   Stage 6: carry propagated into the high word, registered to P
module pipelined_multiplier_32x32
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH   = MUL_WIDTH,
    parameter int unsigned LATENCY = MUL_LATENCY,
    parameter bit          SIGNED  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned W = MUL_WIDTH;
    localparam int unsigned H = MUL_HALF;

    // The internal split below is built for the 32-bit, 6-stage configuration only.
    if (WIDTH != MUL_WIDTH || LATENCY != MUL_LATENCY) begin : g_param_check
        $error("pipelined_multiplier_32x32 supports only WIDTH=32, LATENCY=6");
    end

    // Stage 1
    operand_t       r_a;
    operand_t       r_b;
    // Stage 2
    logic [W-1:0]   w_pp_ll;
    logic [W-1:0]   w_pp_lh;
    logic [W-1:0]   w_pp_hl;
    logic [W-1:0]   w_pp_hh;
    operand_t       r_s2_corr;
    // Stage 3
    logic [W:0]     r_s3_mid;
    logic [W-1:0]   r_s3_ll;
    logic [W-1:0]   r_s3_hh;
    operand_t       r_s3_corr;
    // Stage 4
    logic [W:0]     w_s4_lo_sum;
    logic [W-1:0]   w_s4_hi_sum;
    logic [W-1:0]   r_s4_lo;
    logic [W-1:0]   r_s4_hi;
    logic           r_s4_carry;
    operand_t       r_s4_corr;
    // Stage 5
    logic [W-1:0]   r_s5_lo;
    logic [W-1:0]   r_s5_hi;
    logic           r_s5_carry;
    // Stage 6
    product_t       r_p;

    // Stage 1: capture operands every cycle; no enable by design.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= A;
            r_b <= B;
        end
    end

    // Stage 2: unsigned partial products of the operand halves.
    mul16x16_pp #(
        .PP_WIDTH (H)
    ) u_pp_ll (
        .i_clk (CLK),
        .i_rst (rst),
        .i_a   (r_a[H-1:0]),
        .i_b   (r_b[H-1:0]),
        .o_p   (w_pp_ll)
    );

    mul16x16_pp #(
        .PP_WIDTH (H)
    ) u_pp_lh (
        .i_clk (CLK),
        .i_rst (rst),
        .i_a   (r_a[H-1:0]),
        .i_b   (r_b[W-1:H]),
        .o_p   (w_pp_lh)
    );

    mul16x16_pp #(
        .PP_WIDTH (H)
    ) u_pp_hl (
        .i_clk (CLK),
        .i_rst (rst),
        .i_a   (r_a[W-1:H]),
        .i_b   (r_b[H-1:0]),
        .o_p   (w_pp_hl)
    );

    mul16x16_pp #(
        .PP_WIDTH (H)
    ) u_pp_hh (
        .i_clk (CLK),
        .i_rst (rst),
        .i_a   (r_a[W-1:H]),
        .i_b   (r_b[W-1:H]),
        .o_p   (w_pp_hh)
    );

    // Stage 2: signed fix-up term, computed alongside the partial products.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s2_corr <= '0;
        end else if (SIGNED) begin
            r_s2_corr <= signed_hi_correction(r_a, r_b);
        end else begin
            r_s2_corr <= '0;
        end
    end

    // Stage 3: combine the two middle partial products; carry kept in bit W.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s3_mid  <= '0;
            r_s3_ll   <= '0;
            r_s3_hh   <= '0;
            r_s3_corr <= '0;
        end else begin
            r_s3_mid  <= {1'b0, w_pp_lh} + {1'b0, w_pp_hl};
            r_s3_ll   <= w_pp_ll;
            r_s3_hh   <= w_pp_hh;
            r_s3_corr <= r_s2_corr;
        end
    end

    // Middle sum is weighted by 2^H: low H bits land in the low word, the
    // remaining H+1 bits in the high word. Low-word carry is deferred.
    assign w_s4_lo_sum = {1'b0, r_s3_ll} + {1'b0, r_s3_mid[H-1:0], {H{1'b0}}};
    assign w_s4_hi_sum = r_s3_hh + {{(H-1){1'b0}}, r_s3_mid[W:H]};

    // Stage 4: register the split low/high sums and the low-word carry.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s4_lo    <= '0;
            r_s4_hi    <= '0;
            r_s4_carry <= 1'b0;
            r_s4_corr  <= '0;
        end else begin
            r_s4_lo    <= w_s4_lo_sum[W-1:0];
            r_s4_hi    <= w_s4_hi_sum;
            r_s4_carry <= w_s4_lo_sum[W];
            r_s4_corr  <= r_s3_corr;
        end
    end

    // Stage 5: apply the signed correction to the high word (zero when unsigned).
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s5_lo    <= '0;
            r_s5_hi    <= '0;
            r_s5_carry <= 1'b0;
        end else begin
            r_s5_lo    <= r_s4_lo;
            r_s5_hi    <= r_s4_hi - r_s4_corr;
            r_s5_carry <= r_s4_carry;
        end
    end

    // Stage 6: final carry-propagate into the high word, registered to P.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_p <= '0;
        end else begin
            r_p <= {r_s5_hi + {{(W-1){1'b0}}, r_s5_carry}, r_s5_lo};
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_pipelined_multiplier_32x32.sv
// Directed bench for pipelined_multiplier_32x32: one unsigned and one signed
// instance share stimulus; results are compared against hand-computed values
// and a behavioural reference delayed by the fixed latency.
module tb_pipelined_multiplier_32x32;
    import mul_pkg::*;

    logic     CLK;
    logic     rst;
    operand_t A;
    operand_t B;
    product_t p_u;
    product_t p_s;

    int checks;
    int errors;

    // Per-edge history of reference products and reset samples.
    product_t hist_u[$];
    product_t hist_s[$];
    bit       hist_rst[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    pipelined_multiplier_32x32 #(
        .WIDTH   (32),
        .LATENCY (6),
        .SIGNED  (1'b0)
    ) u_dut_u (
        .CLK (CLK),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (p_u)
    );

    pipelined_multiplier_32x32 #(
        .WIDTH   (32),
        .LATENCY (6),
        .SIGNED  (1'b1)
    ) u_dut_s (
        .CLK (CLK),
        .rst (rst),
        .A   (A),
        .B   (B),
        .P   (p_s)
    );

    function automatic product_t ref_mul(input operand_t a, input operand_t b, input bit sgn);
        product_t xa;
        product_t xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
        return xa * xb;
    endfunction

    task automatic check(input string tag, input product_t obs, input product_t expected);
        checks++;
        if (obs !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expected);
        end
    endtask

    // Present one operand pair for one rising edge; returns 1 time unit after it.
    task automatic tick(input operand_t a, input operand_t b, input logic r);
        A   = a;
        B   = b;
        rst = r;
        @(posedge CLK);
        hist_u.push_back(ref_mul(a, b, 1'b0));
        hist_s.push_back(ref_mul(a, b, 1'b1));
        hist_rst.push_back(r);
        #1;
    endtask

    // P after edge e carries the pair from edge e-5 unless a reset was sampled
    // anywhere in edges e-5..e, in which case it must read 0.
    task automatic check_model(input string tag);
        int       e;
        bit       flushed;
        product_t eu;
        product_t es;
        e       = hist_u.size() - 1;
        flushed = (e < 5);
        if (!flushed) begin
            for (int i = e - 5; i <= e; i++) begin
                if (hist_rst[i]) flushed = 1'b1;
            end
        end
        eu = '0;
        es = '0;
        if (!flushed) begin
            eu = hist_u[e-5];
            es = hist_s[e-5];
        end
        check({tag, "_u"}, p_u, eu);
        check({tag, "_s"}, p_s, es);
        check({tag, "_lo"}, {32'h0, p_s[31:0]}, {32'h0, eu[31:0]});
    endtask

    // Isolated pair surrounded by zeros, checked exactly 6 edges after its sample.
    task automatic single(input string tag, input operand_t a, input operand_t b,
                          input product_t exp_u, input product_t exp_s);
        tick(a, b, 1'b0);
        repeat (5) tick('0, '0, 1'b0);
        check({tag, "_u"}, p_u, exp_u);
        check({tag, "_s"}, p_s, exp_s);
    endtask

    initial begin
        int       k;
        product_t expected;
        operand_t ra;
        operand_t rb;

        checks = 0;
        errors = 0;
        A      = '0;
        B      = '0;
        rst    = 1'b1;

        // Reset; operands present during reset must be discarded.
        tick('0, '0, 1'b1);
        tick(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        check("reset_u", p_u, 64'h0);
        check("reset_s", p_s, 64'h0);
        repeat (6) begin
            tick('0, '0, 1'b0);
            check("post_reset", p_u, 64'h0);
        end

        // Latency: 3*5 sampled at edge n, visible only after edge n+5.
        tick(32'd3, 32'd5, 1'b0);
        check("lat_n0", p_u, 64'h0);
        for (int i = 1; i <= 4; i++) begin
            tick('0, '0, 1'b0);
            check($sformatf("lat_n%0d", i), p_u, 64'h0);
        end
        tick('0, '0, 1'b0);
        check("lat_n5_u", p_u, 64'd15);
        check("lat_n5_s", p_s, 64'd15);
        tick('0, '0, 1'b0);
        check("lat_n6", p_u, 64'h0);

        // Directed extremes.
        single("ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001);
        single("min_x2",  32'h8000_0000, 32'h0000_0002,
               64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000);
        single("zero",    32'h0000_0000, 32'hDEAD_BEEF,
               64'h0, 64'h0);
        single("min_sq",  32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000);
        single("m7_x3",   32'hFFFF_FFF9, 32'h0000_0003,
               64'h0000_0002_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB);
        single("max_sq",  32'h7FFF_FFFF, 32'h7FFF_FFFF,
               64'h3FFF_FFFF_0000_0001, 64'h3FFF_FFFF_0000_0001);
        single("ffff_sq", 32'h0000_FFFF, 32'h0000_FFFF,
               64'h0000_0000_FFFE_0001, 64'h0000_0000_FFFE_0001);
        single("m1_x1",   32'hFFFF_FFFF, 32'h0000_0001,
               64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        single("mid_cry", 32'h0001_0000, 32'h0001_0000,
               64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);

        // Streaming: k*(k+1) for k = 1..20 on consecutive cycles.
        for (int c = 0; c < 25; c++) begin
            if (c < 20) tick(c + 1, c + 2, 1'b0);
            else        tick('0, '0, 1'b0);
            if (c >= 5) begin
                k        = c - 4;
                expected = product_t'(k * (k + 1));
                check($sformatf("stream_k%0d", k), p_u, expected);
            end
        end

        // Reset mid-flight: flushed products must never appear.
        for (int c = 0; c < 5; c++) begin
            tick(10 + c, 32'd3, (c == 3));
            if (c == 3) check("rst_edge", p_u, 64'h0);
            check_model("rst_flush");
        end
        for (int j = 0; j < 6; j++) begin
            tick(20 + j, 32'd2, 1'b0);
            check_model("rst_restream");
        end
        repeat (6) begin
            tick('0, '0, 1'b0);
            check_model("rst_drain");
        end

        // Random pairs with occasional resets.
        repeat (2000) begin
            ra = $urandom();
            rb = $urandom();
            tick(ra, rb, ($urandom_range(63) == 0));
            check_model("rand");
        end
        repeat (6) begin
            tick('0, '0, 1'b0);
            check_model("rand_drain");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_multiplier_32x32.md
Name: pipelined_multiplier_32x32

Overview:
- Fixed-latency, fully pipelined 32x32 -> 64-bit integer multiplier.
- Sits inside the execute stage's multiply functional unit.
- The functional unit latches its operands, then counts a fixed number of cycles before taking the product. The block therefore has no handshake, only a constant latency.
- Accepts a new operand pair every cycle.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 must be supported and verified.
- LATENCY, 6, register stages from operand sample to P. Fixed at 6; the FU_mul cycle counter depends on it.
- SIGNED, 0, 0 = unsigned operands and product; 1 = two's-complement signed operands and product.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- A, input, 32, multiplicand.
- B, input, 32, multiplier.
- P, output, 64, product A*B.

Behaviour:
- Interface: one clock, CLK. Reset rst is synchronous and active-high.
- Timing: A and B are sampled on every rising edge with no enable. The pair sampled at edge n appears on P immediately after edge n+5, i.e. 6 register stages.
- P is driven directly from the final pipeline register, with no combinational path from A/B to P.
- Throughput: one product per cycle. Back-to-back operand pairs produce back-to-back products in order, and every stage advances every cycle.
- Reset:
  - While rst is high at an edge, every pipeline register, including the valid-data and P stages, is cleared to 0.
  - P reads 0 from the edge after rst is first sampled high.
  - After rst is released, P stays 0 until real data sampled after the release reaches the output 6 edges later. Operands sampled during reset are discarded.
  - Reset mid-operation flushes in-flight products; no partial result ever appears.
- Arithmetic:
  - SIGNED=0: P = zero-extended A × zero-extended B, exact to 64 bits.
  - SIGNED=1: sign-extended product.
  - P[31:0] is identical in both modes.
  - No overflow or saturation is possible, since the full 64-bit product is kept.
- Suggested pipeline:
  - Stage 1: register operands.
  - Stage 2: form four 16x16 partial products (AL*BL, AL*BH, AH*BL, AH*BH), registered.
  - Stages 3–5: staged carry-save/adder tree with shifted accumulation, split across the stages to bound the critical path to roughly one 16x16 multiply or one 48-bit add.
  - Stage 6: final carry-propagate add, registered to P.
  - Signed mode: apply a Baugh-Wooley style correction on the high partial products, or sign-extend operands to 33 bits.
  - Any internal split is acceptable provided latency is exactly 6 and results are exact.
- Boundary cases:
  - 0 × anything = 0.
  - 0xFFFFFFFF × 0xFFFFFFFF = 0xFFFFFFFE00000001 when unsigned; 1 when signed.
  - Operands changing every cycle do not interfere with one another.
- Idle behaviour: no X propagation after reset; P never holds X once rst has been applied.

Decomposition:
- Shared package mul_pkg:
  - MUL_WIDTH = 32.
  - MUL_LATENCY = 6, also consumed by the FU_mul counter.
  - typedefs operand_t [31:0] and product_t [63:0].
- One natural sub-module: mul16x16_pp, a registered 16x16 partial-product multiplier, instantiated four times.
- The adder tree and final sum stay in the top module.

Test Plan:
- Latency check: reset, then apply A=3, B=5 for one cycle and A=B=0 otherwise. P=0 through edge n+4, and P=15 right after edge n+5.
- Streaming: drive A=k and B=k+1 for k=1..20 on consecutive cycles. P shows k*(k+1) in order on consecutive cycles, starting 6 edges after the first sample.
- Extremes, SIGNED=0:
  - 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE00000001.
  - 0x80000000×2 gives 0x0000000100000000.
  - 0×0xDEADBEEF gives 0.
- Signed mode, SIGNED=1:
  - -1×-1 gives 1.
  - 0x80000000×0x80000000 gives 0x4000000000000000.
  - -7×3 gives 0xFFFFFFFFFFFFFFEB.
- Reset mid-flight:
  - Stream 5 products, assert rst for 1 cycle at cycle 3, then stream again. P is 0 the edge after rst, none of the flushed products appear, and new products arrive 6 edges after their sample.
- Random: 10,000 random operand pairs per mode against a 64-bit reference model delayed 6 cycles. Zero mismatches, and P[31:0] always equals (A*B) mod 2^32.
